// File: rtl/tx_frame_arbiter_if.sv
// Transmit-path bundle between three frame requesters, the arbiter and the
// transmit encoder. Requester i owns bit i of the per-requester vectors and
// bits [16i+15:16i] of srcdata.
interface tx_frame_arbiter_if;
    logic [2:0]  req;
    logic [2:0]  srcvalid;
    logic [2:0]  srcsof;
    logic [2:0]  srceof;
    logic [47:0] srcdata;
    logic [2:0]  srcready;
    logic [2:0]  grant;
    logic        txready;
    logic        txvalid;
    logic        txsof;
    logic        txeof;
    logic [15:0] txdata;
    logic        txabort;
    logic        busy;

    // Requesters plus encoder side
    modport master (
        output req, srcvalid, srcsof, srceof, srcdata, txready,
        input  srcready, grant, txvalid, txsof, txeof, txdata, txabort, busy
    );

    // Arbiter side
    modport slave (
        input  req, srcvalid, srcsof, srceof, srcdata, txready,
        output srcready, grant, txvalid, txsof, txeof, txdata, txabort, busy
    );
endinterface

// File: rtl/tx_frame_arbiter.sv
// Three-way transmit frame arbiter: ARP reply (0), DHCP (1), data/summary (2).
// A granted requester owns the encoder for a whole frame, followed by a
// 12-cycle inter-frame gap. A 10-bit watchdog aborts a frame that stops
// moving for 1023 cycles.
// Optional build macro TX_ARB_ARP_PRIORITY_EN: ARP always wins in IDLE and
// only DHCP/data rotate; undefined, all three rotate round-robin.
module tx_frame_arbiter (
    input  logic                 clock,
    input  logic                 reset,
    tx_frame_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam logic [9:0] WDOG_LAST = 10'd1022;  // next idle cycle makes 1023
    localparam logic [3:0] GAP_LAST  = 4'd11;     // gap cycles counted 0..11

    state_e      state_q, state_d;
    logic [2:0]  grant_q, grant_d;
    logic [1:0]  last_q,  last_d;
    logic [9:0]  wdog_q,  wdog_d;
    logic [3:0]  gap_q,   gap_d;

    logic [1:0]  winner;
    logic        in_xfer;
    logic        xfer;
    logic        mux_valid, mux_sof, mux_eof;
    logic [15:0] mux_data;

    // Winner search starts after the last-granted index; r is nonzero when used.
    function automatic logic [1:0] pick(input logic [2:0] r, input logic [1:0] last);
        logic [1:0] w;
`ifdef TX_ARB_ARP_PRIORITY_EN
        if (r[0])
            w = 2'd0;
        else if (last == 2'd1)
            w = r[2] ? 2'd2 : 2'd1;
        else
            w = r[1] ? 2'd1 : 2'd2;
`else
        case (last)
            2'd0:    w = r[1] ? 2'd1 : (r[2] ? 2'd2 : 2'd0);
            2'd1:    w = r[2] ? 2'd2 : (r[0] ? 2'd0 : 2'd1);
            default: w = r[0] ? 2'd0 : (r[1] ? 2'd1 : 2'd2);
        endcase
`endif
        return w;
    endfunction

    // Arbitration winner for the current request vector
    always_comb begin
        winner = pick(bus.req, last_q);
    end

    // Word mux selected by the one-hot grant
    always_comb begin
        mux_valid = 1'b0;
        mux_sof   = 1'b0;
        mux_eof   = 1'b0;
        mux_data  = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            if (grant_q[i]) begin
                mux_valid = bus.srcvalid[i];
                mux_sof   = bus.srcsof[i];
                mux_eof   = bus.srceof[i];
                mux_data  = bus.srcdata[16*i +: 16];
            end
        end
    end

    assign in_xfer      = (state_q == XFER);
    assign bus.txvalid  = in_xfer & mux_valid;
    assign bus.txsof    = in_xfer & mux_sof;
    assign bus.txeof    = in_xfer & mux_eof;
    assign bus.txdata   = in_xfer ? mux_data : '0;
    assign bus.srcready = in_xfer ? ({3{bus.txready}} & grant_q) : '0;
    assign xfer         = bus.txvalid & bus.txready;
    assign bus.txabort  = in_xfer & ~xfer & (wdog_q == WDOG_LAST);
    assign bus.grant    = grant_q;
    assign bus.busy     = (state_q != IDLE);

    // Next-state, grant, watchdog and gap-counter logic
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        wdog_d  = wdog_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    grant_d = 3'b001 << winner;
                    last_d  = winner;
                    wdog_d  = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (xfer) begin
                    wdog_d = '0;
                    if (bus.txeof) begin
                        grant_d = '0;
                        gap_d   = '0;
                        state_d = GAP;
                    end
                end else begin
                    wdog_d = wdog_q + 10'd1;
                    if (wdog_q == WDOG_LAST) begin
                        grant_d = '0;
                        gap_d   = '0;
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset clears everything without waiting for a clock
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= 2'd2;
            wdog_q  <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
            gap_q   <= gap_d;
        end
    end

endmodule
